// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_sched_pkg;
  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} sched_state_t;
  localparam logic [3:0] HDR_MAGIC = 4'hA;
endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: search begins one past the last grant and wraps.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant_onehot,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  always_comb begin
    int idx;
    idx          = 0;
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(last) + k;
      if (idx >= N) idx = idx - N;
      if (!any && req[IW'(idx)]) begin
        any                       = 1'b1;
        grant_onehot[IW'(idx)]    = 1'b1;
        grant_idx                 = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ requesters; each grant sends a
// header byte {A, requester} followed by the captured word, LSB first.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int WORD_BYTES = 8
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic [NUM_REQ-1:0]              req_valid_in,
  input  logic [NUM_REQ*WORD_BYTES*8-1:0] req_data_in,
  output logic [NUM_REQ-1:0]              req_ready_out,
  input  logic                            tx_busy_in,
  output logic [7:0]                      tx_byte_out,
  output logic                            tx_trigger_out,
  output logic                            idle_out
);

  localparam int W  = WORD_BYTES * 8;
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(WORD_BYTES + 1);

  sched_state_t      state_q;
  logic [W-1:0]      shift_q;
  logic [BW-1:0]     byte_idx_q;
  logic [IW-1:0]     last_grant_q;
  logic              trig_q;
  logic [7:0]        byte_q;

  logic [NUM_REQ-1:0] grant_onehot;
  logic [IW-1:0]      grant_idx;
  logic               grant_any;
  logic [W-1:0]       win_word;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req          (req_valid_in),
    .last         (last_grant_q),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (grant_any)
  );

  assign win_word = req_data_in[int'(grant_idx)*W +: W];

  // Ready is held low during reset even if the state decode says IDLE.
  assign req_ready_out  = (state_q == IDLE && rst_n_in) ? grant_onehot : '0;
  assign idle_out       = (state_q == IDLE);
  assign tx_trigger_out = trig_q;
  assign tx_byte_out    = byte_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      byte_idx_q   <= '0;
      last_grant_q <= IW'(NUM_REQ - 1);
      trig_q       <= 1'b0;
      byte_q       <= 8'h00;
    end else begin
      trig_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            shift_q      <= win_word;
            byte_idx_q   <= '0;
            last_grant_q <= grant_idx;
            byte_q       <= {HDR_MAGIC, 4'(grant_idx)};
            trig_q       <= 1'b1;
            state_q      <= SEND;
          end
        end
        SEND: state_q <= WAIT_BUSY;
        WAIT_BUSY: begin
          if (tx_busy_in) state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!tx_busy_in) begin
            if (byte_idx_q == BW'(WORD_BYTES)) begin
              state_q <= IDLE;
            end else begin
              // Payload byte byte_idx sits at the bottom of the shift register.
              byte_idx_q <= byte_idx_q + BW'(1);
              byte_q     <= shift_q[7:0];
              shift_q    <= shift_q >> 8;
              trig_q     <= 1'b1;
              state_q    <= SEND;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
